// File: rtl/seg_pkg.sv
// Shared types, default sizing and anode polarity helpers for the 7-segment scanner.
package seg_pkg;

    typedef logic [3:0] nibble_t;

    localparam int DEF_DIGITS    = 4;
    localparam int DEF_TICK_DIV  = 50000;
    localparam int DEF_BLANK_CYC = 16;

    // Anode vectors are built 8 wide (the maximum digit count) and sliced by the user.
    function automatic logic [7:0] an_on(input bit act_low, input logic [7:0] en);
        return act_low ? ~en : en;
    endfunction

    function automatic logic [7:0] an_off(input bit act_low);
        return act_low ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display bus: buffered value write port in, scanned nibble/anode/dp/frame outputs back.
interface seg_scan_mux_if #(parameter int DIGITS = seg_pkg::DEF_DIGITS);
    import seg_pkg::*;

    logic [4*DIGITS-1:0] val_in;
    logic [DIGITS-1:0]   dp_in;
    logic                val_we;
    nibble_t             hex;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_start;

    modport master (output val_in, dp_in, val_we, input hex, dp, an, frame_start);
    modport slave  (input val_in, dp_in, val_we, output hex, dp, an, frame_start);

endinterface

// File: rtl/seg_tick_gen.sv
// Slot prescaler: slot_pos is the position the next registered output step represents.
// Holds at 0 for the first edge after reset so slot 0 of the first frame is fully visible.
module seg_tick_gen #(
    parameter int TICK_DIV = seg_pkg::DEF_TICK_DIV,
    parameter int PW       = $clog2(TICK_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [PW-1:0] slot_pos,
    output logic          slot_wrap
);

    logic          run;
    logic [PW-1:0] pos_q;

    always_comb begin
        slot_wrap = run && (pos_q == PW'(TICK_DIV - 1));
        slot_pos  = '0;
        if (run && !slot_wrap) begin
            slot_pos = pos_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            pos_q <= '0;
        end else begin
            run   <= 1'b1;
            pos_q <= slot_pos;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Double-buffered multiplexed 7-seg scanner; outputs registered, write-to-display at next frame.
// No backpressure: val_we always accepted; optional LEADING_ZERO_BLANK_EN hides leading zero digits.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS     = DEF_DIGITS,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int BLANK_CYC  = DEF_BLANK_CYC,
    parameter int AN_ACT_LOW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW    = $clog2(TICK_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] val;
        logic [DIGITS-1:0]   dp;
    } buf_t;

    logic [PW-1:0]    slot_pos;
    logic             slot_wrap;
    logic [IDX_W-1:0] idx, idx_nxt;
    buf_t             shadow, active, act_nxt;
    logic             pending, boundary;
    logic             shown, lit;
    logic [7:0]       an_en, an_lvl, an_idle;
    nibble_t          hex_nxt, hex_q;
    logic             dp_q, fs_q;
    logic [DIGITS-1:0] an_q;

    seg_tick_gen #(.TICK_DIV(TICK_DIV), .PW(PW)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_pos  (slot_pos),
        .slot_wrap (slot_wrap)
    );

    always_comb begin
        boundary = slot_wrap && (idx == LAST_IDX);
        idx_nxt  = idx;
        if (slot_wrap) begin
            idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end

        // A write landing on the boundary edge bypasses the shadow entirely.
        act_nxt = active;
        if (boundary) begin
            if (bus.val_we) begin
                act_nxt = {bus.val_in, bus.dp_in};
            end else if (pending) begin
                act_nxt = shadow;
            end
        end

        hex_nxt = nibble_t'(act_nxt.val >> (4 * idx_nxt));
        shown   = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        shown = (idx_nxt == '0) || act_nxt.dp[idx_nxt] ||
                ((act_nxt.val >> (4 * idx_nxt)) != '0);
`endif
        lit     = shown && (slot_pos >= PW'(BLANK_CYC));
        an_en   = lit ? (8'd1 << idx_nxt) : 8'd0;
        an_lvl  = an_on(AN_ACT_LOW != 0, an_en);
        an_idle = an_off(AN_ACT_LOW != 0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            hex_q   <= '0;
            dp_q    <= 1'b0;
            an_q    <= an_idle[DIGITS-1:0];
            fs_q    <= 1'b0;
        end else begin
            idx    <= idx_nxt;
            active <= act_nxt;
            if (bus.val_we && !boundary) begin
                shadow  <= {bus.val_in, bus.dp_in};
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            hex_q <= hex_nxt;
            dp_q  <= lit && act_nxt.dp[idx_nxt];
            an_q  <= an_lvl[DIGITS-1:0];
            fs_q  <= (slot_pos == '0) && (idx_nxt == '0);
        end
    end

    assign bus.hex         = hex_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed + random bench for seg_scan_mux (4 digits, 8-cycle slots, 2 blank cycles, active-low anodes).
module tb_seg_scan_mux;

    localparam int ND = 4;
    localparam int TD = 8;
    localparam int BL = 2;
    localparam int FRAME = ND * TD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_mux_if #(.DIGITS(ND)) bus ();

    seg_scan_mux #(.DIGITS(ND), .TICK_DIV(TD), .BLANK_CYC(BL), .AN_ACT_LOW(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int t       = 0;

    // Reference state: what the display shows, and what waits for the next frame.
    logic [15:0] m_val, s_val;
    logic [3:0]  m_dp, s_dp;
    bit          m_pend;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
    endtask

    function automatic bit shown(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d == 0) || m_dp[d] || ((m_val >> (4 * d)) != 16'h0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        t = 0; m_val = '0; m_dp = '0; s_val = '0; s_dp = '0; m_pend = 1'b0;
    endtask

    // One clock edge: apply the sampled write to the model, then check all outputs.
    task automatic step();
        int p, d;
        bit lit;
        logic [3:0] one, exp_an;
        @(posedge clk);
        t++;
        if (t > 1 && (t - 1) % FRAME == 0) begin
            if (bus.val_we) begin
                m_val = bus.val_in; m_dp = bus.dp_in;
            end else if (m_pend) begin
                m_val = s_val; m_dp = s_dp;
            end
            m_pend = 1'b0;
        end else if (bus.val_we) begin
            s_val = bus.val_in; s_dp = bus.dp_in; m_pend = 1'b1;
        end
        #1;
        p   = (t - 1) % TD;
        d   = ((t - 1) / TD) % ND;
        lit = (p >= BL) && shown(d);
        one = 4'b0001;
        exp_an = lit ? ~(one << d) : 4'hF;
        chk("hex", 16'(bus.hex), 16'((m_val >> (4 * d)) & 16'hF));
        chk("an", 16'(bus.an), 16'(exp_an));
        chk("dp", 16'(bus.dp), 16'(lit && m_dp[d]));
        chk("frame_start", 16'(bus.frame_start), 16'((t - 1) % FRAME == 0));
    endtask

    task automatic write(input logic [15:0] v, input logic [3:0] dpv);
        bus.val_in = v; bus.dp_in = dpv; bus.val_we = 1'b1;
        step();
        bus.val_we = 1'b0;
    endtask

    initial begin
        bus.val_in = '0; bus.dp_in = '0; bus.val_we = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", 16'(bus.an), 16'hF);
        chk("rst_hex", 16'(bus.hex), 16'h0);
        chk("rst_dp", 16'(bus.dp), 16'h0);
        chk("rst_fs", 16'(bus.frame_start), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan with zero value
        repeat (2 * FRAME + 5) step();

        // Mid-frame write held until the next boundary
        write(16'h12AF, 4'b0000);
        repeat (2 * FRAME) step();

        // Two writes in one frame: last one wins
        repeat (3) step();
        write(16'h1111, 4'b0001);
        repeat (4) step();
        write(16'h2222, 4'b0010);
        repeat (2 * FRAME) step();

        // Pending write overridden by a write on the boundary edge itself
        repeat (5) step();
        write(16'h1234, 4'b0000);
        while (t % FRAME != 0) step();
        write(16'h0BEE, 4'b1000);
        repeat (2 * FRAME) step();

        // Leading zeros with a dp on digit 2
        write(16'h0005, 4'b0100);
        repeat (2 * FRAME) step();

        // Random writes, biased toward small values so leading zeros appear
        for (int i = 0; i < 600; i++) begin
            bus.val_we = ($urandom_range(0, 7) == 0);
            bus.val_in = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
            bus.dp_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
        end
        bus.val_we = 1'b0;
        repeat (FRAME) step();

        // Asynchronous reset at p=5 of digit 2
        while ((t - 1) % FRAME != 2 * TD + 5) step();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_an", 16'(bus.an), 16'hF);
        chk("arst_hex", 16'(bus.hex), 16'h0);
        chk("arst_dp", 16'(bus.dp), 16'h0);
        chk("arst_fs", 16'(bus.frame_start), 16'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_an", 16'(bus.an), 16'hF);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (FRAME + 8) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
